fp_result_buffer: RTL and testbench

//   Downstream stage of the FP32 adder/subtracter. The adder has no backpressure.

---
 rtl/fp_result_buffer_pkg.sv | 36 +++
 rtl/fp_result_buffer_fifo_mem_2p.sv | 26 ++
 rtl/fp_result_buffer.sv | 115 +++++++++++
 tb/tb_fp_result_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_result_buffer_pkg.sv
// Shared FP32 field layout, result flag indices and the buffer entry format,
// common to the adder and its result buffer.
package fp_result_buffer_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int FRAC_W  = 23;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  localparam int F_ZERO = 0;
  localparam int F_INF  = 1;
  localparam int F_NAN  = 2;
  localparam int F_OVF  = 3;

  localparam int FLAG_W  = 4;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = FLAG_W + DATA_W;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [FLAG_W-1:0] classify(input logic [DATA_W-1:0] d, input logic ovf);
    logic [7:0] e;
    logic       frac_nz;
    e       = d[EXP_MSB:EXP_LSB];
    frac_nz = |d[FRAC_W-1:0];
    classify         = '0;
    classify[F_ZERO] = (e == 8'h00) && !frac_nz;
    classify[F_INF]  = (e == EXP_ALL1) && !frac_nz;
    classify[F_NAN]  = (e == EXP_ALL1) && frac_nz;
    classify[F_OVF]  = ovf;
  endfunction

endpackage

// File: rtl/fp_result_buffer_fifo_mem_2p.sv
// DEPTH x W register array: one synchronous write port, asynchronous read.
// Storage is deliberately not reset.
module fifo_mem_2p
  import fp_result_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/fp_result_buffer.sv
// Result buffer behind the FP32 adder: classifies and queues every result,
// presents it FWFT over ready/valid, and issues credits upstream.
module fp_result_buffer
  import fp_result_buffer_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 2,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  output logic          can_issue,
  input  logic [31:0]   in_res,
  input  logic          in_vld,
  input  logic          in_ovf,
  output logic [31:0]   out_data,
  output logic [3:0]    out_flags,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [AW:0]   count,
  output logic          sticky_ovf,
  output logic          sticky_nan,
  output logic          drop_err,
  input  logic          clr_sticky
);

  // inflight is sized to hold DEPTH+MAX_INFLIGHT so protocol-violating
  // issues are still counted without wrapping.
  localparam int IW = $clog2(DEPTH + MAX_INFLIGHT + 2);
  localparam int SW = IW + 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] MAXF    = IW'(MAX_INFLIGHT);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] inflight;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [SW-1:0] pending;
  entry_t        wr_entry;
  entry_t        rd_entry;

  always_comb begin
    out_vld  = (count != '0);
    full     = (count == DEPTH_C);
    pop      = out_vld && out_rdy;
    push     = in_vld && (!full || pop);
    drop     = in_vld && full && !pop;
    wr_entry = '{flags: classify(in_res, in_ovf), data: in_res};
  end

  fifo_mem_2p #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk (clk),
    .we  (push),
    .wa  (wr_ptr),
    .wd  (wr_entry),
    .ra  (rd_ptr),
    .rd  (rd_entry)
  );

  assign out_data  = rd_entry.data;
  assign out_flags = rd_entry.flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating at zero absorbs results still in the adder across a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue && !in_vld) begin
      if (inflight != '1) inflight <= inflight + 1'b1;
    end else if (!issue && in_vld) begin
      if (inflight != '0) inflight <= inflight - 1'b1;
    end
  end

  always_comb begin
    pending   = SW'(count) + SW'(inflight);
    can_issue = (inflight < MAXF) && (pending < DEPTH_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_nan <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      sticky_ovf <= (sticky_ovf && !clr_sticky) || (push && wr_entry.flags[F_OVF]);
      sticky_nan <= (sticky_nan && !clr_sticky) || (push && wr_entry.flags[F_NAN]);
      drop_err   <= (drop_err && !clr_sticky) || drop;
    end
  end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed bench for fp_result_buffer: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_fp_result_buffer;

  localparam int DEPTH = 8;
  localparam int MAXI  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_ovf = 1'b0;
  logic        out_rdy = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [31:0] in_res = '0;
  logic        can_issue;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic        out_vld;
  logic [3:0]  count;
  logic        sticky_ovf;
  logic        sticky_nan;
  logic        drop_err;

  fp_result_buffer #(
    .DEPTH        (DEPTH),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .can_issue  (can_issue),
    .in_res     (in_res),
    .in_vld     (in_vld),
    .in_ovf     (in_ovf),
    .out_data   (out_data),
    .out_flags  (out_flags),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .count      (count),
    .sticky_ovf (sticky_ovf),
    .sticky_nan (sticky_nan),
    .drop_err   (drop_err),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {flags,data}, inflight as a plain integer.
  logic [35:0] mq[$];
  int          m_infl = 0;
  bit          m_sovf = 1'b0;
  bit          m_snan = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_pop;
  bit          m_acc;
  logic [3:0]  m_fl;

  function automatic logic [3:0] fp_class(input logic [31:0] d, input logic ovf);
    int unsigned e;
    int unsigned f;
    e = (d >> 23) & 32'd255;
    f = d & 32'h007F_FFFF;
    return {ovf, (e == 255 && f != 0), (e == 255 && f == 0), (e == 0 && f == 0)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_infl = 0;
      m_sovf = 1'b0;
      m_snan = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_pop = (mq.size() != 0) && out_rdy;
      m_acc = in_vld && ((mq.size() < DEPTH) || m_pop);
      m_fl  = fp_class(in_res, in_ovf);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back({m_fl, in_res});
      m_sovf = (m_sovf && !clr_sticky) || (m_acc && m_fl[3]);
      m_snan = (m_snan && !clr_sticky) || (m_acc && m_fl[2]);
      m_drop = (m_drop && !clr_sticky) || (in_vld && !m_acc);
      m_infl = m_infl + int'(issue) - int'(in_vld);
      if (m_infl < 0) m_infl = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_out_vld", 36'(out_vld), 36'(mq.size() != 0));
      chk("mon_count", 36'(count), 36'(mq.size()));
      chk("mon_can_issue", 36'(can_issue),
          36'((m_infl < MAXI) && (mq.size() + m_infl < DEPTH)));
      chk("mon_sticky_ovf", 36'(sticky_ovf), 36'(m_sovf));
      chk("mon_sticky_nan", 36'(sticky_nan), 36'(m_snan));
      chk("mon_drop_err", 36'(drop_err), 36'(m_drop));
      if (mq.size() != 0) chk("mon_head", {out_flags, out_data}, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic ovf);
    in_res = d;
    in_ovf = ovf;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    in_ovf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("reset_out_vld", 36'(out_vld), 36'd0);
    chk("reset_can_issue", 36'(can_issue), 36'd1);
    chk("reset_count", 36'(count), 36'd0);
    chk("reset_sticky", 36'({sticky_ovf, sticky_nan, drop_err}), 36'd0);

    // Single push, one-cycle latency to out_vld
    push(32'h3F80_0000, 1'b0);
    chk("t1_out_vld", 36'(out_vld), 36'd1);
    chk("t1_out_data", 36'(out_data), 36'h0_3F80_0000);
    chk("t1_out_flags", 36'(out_flags), 36'd0);
    chk("t1_count", 36'(count), 36'd1);
    chk("t1_model_size", 36'(mq.size()), 36'd1);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    chk("t1_drained", 36'(count), 36'd0);

    // Classification in FIFO order
    push(32'h7FC0_0000, 1'b0);
    push(32'h7F80_0000, 1'b0);
    push(32'h0000_0000, 1'b1);
    chk("t2_count", 36'(count), 36'd3);
    chk("t2_flags_nan", 36'(out_flags), 36'b0100);
    chk("t2_model_head", mq[0], 36'h4_7FC0_0000);
    chk("t2_sticky_nan", 36'(sticky_nan), 36'd1);
    chk("t2_sticky_ovf", 36'(sticky_ovf), 36'd1);
    out_rdy = 1'b1;
    tick();
    chk("t2_flags_inf", 36'(out_flags), 36'b0010);
    tick();
    chk("t2_flags_zero_ovf", 36'(out_flags), 36'b1001);
    tick();
    out_rdy = 1'b0;
    chk("t2_drained", 36'(count), 36'd0);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("t2_cleared", 36'({sticky_ovf, sticky_nan}), 36'd0);

    // Fill, overflow drop, then push+pop while full
    for (int i = 0; i < 8; i++) push(32'h100 + i, 1'b0);
    chk("t3_full_count", 36'(count), 36'd8);
    chk("t3_full_can_issue", 36'(can_issue), 36'd0);
    push(32'h4000_0000, 1'b0);
    chk("t3_drop_err", 36'(drop_err), 36'd1);
    chk("t3_drop_count", 36'(count), 36'd8);
    chk("t3_drop_head", 36'(out_data), 36'h100);
    in_res = 32'h200; in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    chk("t3_pushpop_count", 36'(count), 36'd8);
    for (int i = 1; i < 8; i++) begin
      chk("t3_order", 36'(out_data), 36'(32'h100 + i));
      tick();
    end
    chk("t3_order_last", 36'(out_data), 36'h200);
    tick();
    out_rdy = 1'b0;
    chk("t3_drained", 36'(count), 36'd0);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("t3_drop_cleared", 36'(drop_err), 36'd0);

    // Credit limits
    issue = 1'b1;
    tick();
    chk("t4_one_inflight", 36'(can_issue), 36'd1);
    tick();
    issue = 1'b0;
    chk("t4_max_inflight", 36'(can_issue), 36'd0);
    push(32'h300, 1'b0);
    chk("t4_one_back", 36'(can_issue), 36'd1);
    push(32'h301, 1'b0);
    for (int i = 2; i < 7; i++) push(32'h300 + i, 1'b0);
    chk("t4_count7", 36'(count), 36'd7);
    chk("t4_count7_credit", 36'(can_issue), 36'd1);
    issue = 1'b1; tick(); issue = 1'b0;
    chk("t4_count7_inflight1", 36'(can_issue), 36'd0);

    // Asynchronous reset mid-operation with one op in flight
    out_rdy = 1'b1; tick(); tick(); out_rdy = 1'b0;
    chk("t5_count5", 36'(count), 36'd5);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out_vld", 36'(out_vld), 36'd0);
    chk("t5_rst_count", 36'(count), 36'd0);
    chk("t5_rst_can_issue", 36'(can_issue), 36'd1);
    tick();
    rst = 1'b0;
    push(32'h400, 1'b0);
    chk("t5_count", 36'(count), 36'd1);
    chk("t5_out_vld", 36'(out_vld), 36'd1);
    chk("t5_no_underflow", 36'(can_issue), 36'd1);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;

    // Set wins over clear
    push(32'h7FC0_0001, 1'b0);
    chk("t6_nan_set", 36'(sticky_nan), 36'd1);
    clr_sticky = 1'b1; in_res = 32'h7FC0_0000; in_vld = 1'b1;
    tick();
    clr_sticky = 1'b0; in_vld = 1'b0;
    chk("t6_set_wins", 36'(sticky_nan), 36'd1);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("t6_cleared", 36'(sticky_nan), 36'd0);

    repeat (2) tick();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
